// File: rtl/core_bp_pkg.sv
// Shared branch-predictor types: 2-bit saturating pattern encoding, the queued
// update record, and the pattern training function.
package core_bp_pkg;

  localparam int BP_PATTERN_W = 2;

  typedef enum logic [BP_PATTERN_W-1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bp_pattern_e;

  typedef struct packed {
    logic [31:0]             pc;
    logic [BP_PATTERN_W-1:0] pattern;
    logic                    taken;
    logic [31:0]             target;
  } bp_update_t;

  localparam int BP_UPDATE_W = $bits(bp_update_t);

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [BP_PATTERN_W-1:0] sat_update(input logic [BP_PATTERN_W-1:0] pattern,
                                                         input logic taken);
    logic [BP_PATTERN_W-1:0] nxt;
    nxt = pattern;
    if (taken) begin
      if (pattern != BP_PATTERN_W'(ST)) nxt = pattern + 2'd1;
    end else begin
      if (pattern != BP_PATTERN_W'(SNT)) nxt = pattern - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_bco_update_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and an extra port that
// rewrites the most recently pushed entry in place.
module fetch_bco_update_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     tail_we,
  input  logic [W-1:0]             tail_data,
  output logic [W-1:0]             head_data,
  output logic [W-1:0]             tail_rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  tail_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign tail_ptr = wr_ptr - (AW+1)'(1);

  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign head_data  = mem[rd_ptr[AW-1:0]];
  assign tail_rdata = mem[tail_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    if (tail_we && !empty && !do_push) mem[tail_ptr[AW-1:0]] <= tail_data;
  end

endmodule

// File: rtl/fetch_bco_update.sv
// Turns BRU branch-correction events into a one-cycle frontend redirect and a
// queued predictor training write, coalescing repeat hits on the queue tail.
module fetch_bco_update
  import core_bp_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int INDEX_BITS = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_bco_valid,
  input  logic [31:0]             i_bco_pc,
  input  logic [1:0]              i_bco_oldpattern,
  input  logic                    i_bco_taken,
  input  logic [31:0]             i_bco_target,
  output logic                    o_redirect_valid,
  output logic [31:0]             o_redirect_pc,
  output logic                    o_bp_wvalid,
  input  logic                    i_bp_wready,
  output logic [INDEX_BITS-1:0]   o_bp_windex,
  output logic [29-INDEX_BITS:0]  o_bp_wtag,
  output logic [1:0]              o_bp_wpattern,
  output logic [31:0]             o_bp_wtarget,
  output logic                    o_bp_wtaken,
  output logic [7:0]              o_drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  bp_update_t  head;
  bp_update_t  tail;
  bp_update_t  new_entry;
  logic        empty;
  logic        full;
  logic [CW-1:0] count;
  logic        pop;
  logic        coalesce;
  logic        push;
  logic        drop;
  logic [1:0]  old_pattern;

  // Predictor write handshake: o_bp_wvalid rises only when an entry is queued,
  // the head fields hold steady until the cycle where o_bp_wvalid and
  // i_bp_wready are both high, and that cycle transfers exactly one entry.
  assign o_bp_wvalid = !empty;
  assign pop         = o_bp_wvalid && i_bp_wready;

  // A single queued entry that is leaving this cycle can no longer be edited.
  assign coalesce = i_bco_valid && !empty && (tail.pc == i_bco_pc)
                    && !(pop && (count == CW'(1)));

  assign old_pattern = coalesce ? tail.pattern : i_bco_oldpattern;

  always_comb begin
    new_entry         = '0;
    new_entry.pc      = i_bco_pc;
    new_entry.pattern = sat_update(old_pattern, i_bco_taken);
    new_entry.taken   = i_bco_taken;
    new_entry.target  = i_bco_target;
  end

  assign push = i_bco_valid && !coalesce && (!full || pop);
  assign drop = i_bco_valid && !coalesce && full && !pop;

  fetch_bco_update_fifo #(
    .DEPTH (DEPTH),
    .W     (BP_UPDATE_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (new_entry),
    .pop        (pop),
    .tail_we    (coalesce),
    .tail_data  (new_entry),
    .head_data  (head),
    .tail_rdata (tail),
    .empty      (empty),
    .full       (full),
    .count      (count)
  );

  // Head fields are masked while idle so stale storage never reaches the port.
  assign o_bp_windex   = o_bp_wvalid ? head.pc[INDEX_BITS+1:2] : '0;
  assign o_bp_wtag     = o_bp_wvalid ? head.pc[31:INDEX_BITS+2] : '0;
  assign o_bp_wpattern = o_bp_wvalid ? head.pattern : '0;
  assign o_bp_wtarget  = o_bp_wvalid ? head.target : '0;
  assign o_bp_wtaken   = o_bp_wvalid ? head.taken : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
      o_drop_cnt       <= '0;
    end else begin
      o_redirect_valid <= i_bco_valid;
      if (i_bco_valid) o_redirect_pc <= i_bco_target;
      if (drop && (o_drop_cnt != 8'hFF)) o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fetch_bco_update.sv
// Directed bench for fetch_bco_update with a scoreboard of expected predictor
// writes and a cycle model of the redirect register.
module tb_fetch_bco_update;

  logic        clk;
  logic        reset;
  logic        i_bco_valid;
  logic [31:0] i_bco_pc;
  logic [1:0]  i_bco_oldpattern;
  logic        i_bco_taken;
  logic [31:0] i_bco_target;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        o_bp_wvalid;
  logic        i_bp_wready;
  logic [5:0]  o_bp_windex;
  logic [23:0] o_bp_wtag;
  logic [1:0]  o_bp_wpattern;
  logic [31:0] o_bp_wtarget;
  logic        o_bp_wtaken;
  logic [7:0]  o_drop_cnt;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  logic [64:0] exp_q[$];
  logic        exp_rv  = 1'b0;
  logic [31:0] exp_rpc = '0;

  fetch_bco_update #(.DEPTH(4), .INDEX_BITS(6)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_bco_valid      (i_bco_valid),
    .i_bco_pc         (i_bco_pc),
    .i_bco_oldpattern (i_bco_oldpattern),
    .i_bco_taken      (i_bco_taken),
    .i_bco_target     (i_bco_target),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc),
    .o_bp_wvalid      (o_bp_wvalid),
    .i_bp_wready      (i_bp_wready),
    .o_bp_windex      (o_bp_windex),
    .o_bp_wtag        (o_bp_wtag),
    .o_bp_wpattern    (o_bp_wpattern),
    .o_bp_wtarget     (o_bp_wtarget),
    .o_bp_wtaken      (o_bp_wtaken),
    .o_drop_cnt       (o_drop_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] mk(input logic [31:0] pc, input logic [1:0] pat,
                                     input logic taken, input logic [31:0] tgt);
    return {pc[7:2], pc[31:8], pat, taken, tgt};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bco(input logic [31:0] pc, input logic [1:0] old, input logic taken,
                     input logic [31:0] tgt);
    i_bco_valid      = 1'b1;
    i_bco_pc         = pc;
    i_bco_oldpattern = old;
    i_bco_taken      = taken;
    i_bco_target     = tgt;
    tick();
    i_bco_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    i_bp_wready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check(tag, 65'(exp_q.size()), 65'(0));
    tick();
    check({tag, "_idle"}, 65'(o_bp_wvalid), 65'(0));
  endtask

  // Redirect reference: registered copy of the event, pc held between events.
  always @(posedge clk) begin
    if (reset) begin
      exp_rv  = 1'b0;
      exp_rpc = '0;
    end else begin
      exp_rv = i_bco_valid;
      if (i_bco_valid) exp_rpc = i_bco_target;
    end
  end

  // Scoreboard: compare redirect each cycle and every accepted predictor write.
  always @(negedge clk) begin
    check("redirect_valid", 65'(o_redirect_valid), 65'(exp_rv));
    check("redirect_pc", 65'(o_redirect_pc), 65'(exp_rpc));
    if (o_bp_wvalid === 1'b1 && i_bp_wready === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_write", 65'(o_bp_wvalid), 65'(0));
      else check("bp_write", {o_bp_windex, o_bp_wtag, o_bp_wpattern, o_bp_wtaken, o_bp_wtarget},
                 exp_q.pop_front());
    end
  end

  initial begin
    reset            = 1'b1;
    i_bco_valid      = 1'b0;
    i_bco_pc         = '0;
    i_bco_oldpattern = '0;
    i_bco_taken      = 1'b0;
    i_bco_target     = '0;
    i_bp_wready      = 1'b0;
    repeat (3) tick();
    check("rst_wvalid", 65'(o_bp_wvalid), 65'(0));
    check("rst_drop", 65'(o_drop_cnt), 65'(0));
    check("rst_windex", 65'(o_bp_windex), 65'(0));
    check("rst_wpattern", 65'(o_bp_wpattern), 65'(0));
    check("rst_wtarget", 65'(o_bp_wtarget), 65'(0));
    reset = 1'b0;
    tick();

    // Single event, written out immediately
    i_bp_wready = 1'b1;
    bco(32'h1000, 2'd1, 1'b1, 32'h2000);
    exp_q.push_back(mk(32'h1000, 2'd2, 1'b1, 32'h2000));
    check("t1_wvalid", 65'(o_bp_wvalid), 65'(1));
    check("t1_windex", 65'(o_bp_windex), 65'(0));
    drain("t1_drain");

    // Overflow: five distinct events into a stalled four-entry queue
    i_bp_wready = 1'b0;
    bco(32'h100, 2'd1, 1'b1, 32'h180); exp_q.push_back(mk(32'h100, 2'd2, 1'b1, 32'h180));
    bco(32'h104, 2'd1, 1'b0, 32'h108); exp_q.push_back(mk(32'h104, 2'd0, 1'b0, 32'h108));
    bco(32'h108, 2'd2, 1'b1, 32'h400); exp_q.push_back(mk(32'h108, 2'd3, 1'b1, 32'h400));
    bco(32'h10c, 2'd2, 1'b0, 32'h110); exp_q.push_back(mk(32'h10c, 2'd1, 1'b0, 32'h110));
    bco(32'h110, 2'd0, 1'b1, 32'h500);
    tick();
    check("t2_drop", 65'(o_drop_cnt), 65'(1));
    check("t2_head_stable", 65'(o_bp_windex), 65'(6'h00));
    drain("t2_drain");

    // Saturation at both ends
    bco(32'h200, 2'd3, 1'b1, 32'h300); exp_q.push_back(mk(32'h200, 2'd3, 1'b1, 32'h300));
    bco(32'h204, 2'd0, 1'b0, 32'h208); exp_q.push_back(mk(32'h204, 2'd0, 1'b0, 32'h208));
    drain("t3_drain");

    // Coalesce on the tail: stored pattern is used, incoming old pattern ignored
    i_bp_wready = 1'b0;
    bco(32'h40, 2'd1, 1'b1, 32'h80);
    bco(32'h40, 2'd0, 1'b1, 32'h90);
    exp_q.push_back(mk(32'h40, 2'd3, 1'b1, 32'h90));
    check("t4_pattern", 65'(o_bp_wpattern), 65'(3));
    check("t4_target", 65'(o_bp_wtarget), 65'(32'h90));
    check("t4_drop", 65'(o_drop_cnt), 65'(1));
    drain("t4_drain");

    // Full queue with simultaneous pop accepts the push
    i_bp_wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bco(32'h500 + 32'(i * 4), 2'd2, 1'b0, 32'h504 + 32'(i * 4));
      exp_q.push_back(mk(32'h500 + 32'(i * 4), 2'd1, 1'b0, 32'h504 + 32'(i * 4)));
    end
    i_bp_wready = 1'b1;
    bco(32'h600, 2'd1, 1'b1, 32'h640);
    exp_q.push_back(mk(32'h600, 2'd2, 1'b1, 32'h640));
    i_bp_wready = 1'b0;
    check("t5_drop_kept", 65'(o_drop_cnt), 65'(1));
    bco(32'h700, 2'd1, 1'b1, 32'h740);
    check("t5_still_full", 65'(o_drop_cnt), 65'(2));
    drain("t5_drain");

    // Reset with entries pending and an event in the reset cycle
    i_bp_wready = 1'b0;
    bco(32'h800, 2'd1, 1'b1, 32'h880);
    bco(32'h804, 2'd1, 1'b1, 32'h884);
    bco(32'h808, 2'd1, 1'b1, 32'h888);
    reset = 1'b1;
    bco(32'h900, 2'd1, 1'b1, 32'h980);
    reset = 1'b0;
    check("t6_wvalid", 65'(o_bp_wvalid), 65'(0));
    check("t6_redirect", 65'(o_redirect_valid), 65'(0));
    check("t6_drop", 65'(o_drop_cnt), 65'(0));
    i_bp_wready = 1'b1;
    repeat (5) tick();
    check("t6_flushed", 65'(o_bp_wvalid), 65'(0));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
